// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the multicycle memory access sequencer.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    WR_PULSE = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 7;
  localparam int CNT_W       = 3;

endpackage

// File: rtl/mem_access_seq.sv
// Multicycle read/write sequencer with a one-cycle Done handshake back to the control FSM.
// Optional misalignment trap enabled by defining MEM_ACCESS_ALIGN_CHECK_EN.
module mem_access_seq
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WrData,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RdData,
  output logic              AlignErr,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWr,
  output logic [DATA_W-1:0] MemWrData,
  input  logic [DATA_W-1:0] MemRdData
);

  generate
    if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_bad
      $error("mem_access_seq: MEM_LAT outside supported range");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                align_err_q;
  logic                mem_wr_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wr_data_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                misaligned;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misaligned = (Addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      align_err_q   <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_data_q     <= '0;
    end else begin
      // Pulse outputs default low; each state raises what it needs for the next cycle.
      done_q      <= 1'b0;
      align_err_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req) begin
            mem_addr_q    <= Addr;
            mem_wr_data_q <= WrData;
            busy_q        <= 1'b1;
            if (misaligned) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              align_err_q <= 1'b1;
            end else if (Wr) begin
              state_q  <= WR_PULSE;
              mem_wr_q <= 1'b1;
            end else begin
              state_q <= RD_WAIT;
              cnt_q   <= CNT_LOAD;
            end
          end
        end
        RD_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rd_data_q <= MemRdData;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end
        end
        WR_PULSE: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign AlignErr  = align_err_q;
  assign MemWr     = mem_wr_q;
  assign MemAddr   = mem_addr_q;
  assign MemWrData = mem_wr_data_q;
  assign RdData    = rd_data_q;

endmodule
